// File: rtl/bram_stream_pkg.sv
// Shared types for the BRAM stream reader: FSM encoding and return-FIFO sizing.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Room for every read the BRAM pipeline can hold, plus one word draining and one landing.
  function automatic int fifo_depth(input int bram_latency);
    return bram_latency + 2;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO for BRAM return words; depth need not be a power of two.
// Zero-latency registered head; push accepted when full only alongside a pop.
module bram_rd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a (base, length) run of BRAM words and streams them out as AXI-Stream.
// First beat BRAM_LATENCY+2 cycles after start; credit-throttled reads give full tready backpressure.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DATA_DEPTH   = 1024,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int LEN_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int FIFO_DEPTH = fifo_depth(BRAM_LATENCY);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int OW         = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2) + 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic                    en_last;
  logic [BRAM_LATENCY-1:0] sr_vld;
  logic [BRAM_LATENCY-1:0] sr_last;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH:0]     fifo_rdata;
  logic [OW-1:0]           outstanding;
  logic                    pop;
  logic                    credit;
  logic                    issue;
  logic                    accept;
  logic                    finish;

  assign pop    = m_axis_tvalid && m_axis_tready;
  assign accept = (state == IDLE) && start;
  assign finish = (state == DRAIN) && pop && m_axis_tlast;

  // Reads in the BRAM pipeline (registered enable plus shift stages) plus words buffered.
  always_comb begin
    outstanding = OW'(fifo_count) + OW'(bram_en);
    for (int i = 0; i < BRAM_LATENCY; i++) outstanding = outstanding + OW'(sr_vld[i]);
  end

  // A word popped this edge frees its slot in time for the read issued on the same edge.
  assign credit = outstanding < (OW'(FIFO_DEPTH) + OW'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && (length != '0)) state_nxt = ISSUE;
      ISSUE:   if (issue && (remaining == LEN_WIDTH'(1))) state_nxt = DRAIN;
      DRAIN:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == ISSUE) && credit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      en_last   <= 1'b0;
      addr_cnt  <= '0;
      remaining <= '0;
      sr_vld    <= '0;
      sr_last   <= '0;
    end else begin
      done    <= (accept && (length == '0)) || finish;
      bram_en <= issue;
      if (accept) begin
        addr_cnt  <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr_cnt  <= (addr_cnt == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (issue) begin
        bram_addr <= addr_cnt;
        en_last   <= (remaining == LEN_WIDTH'(1));
      end
      // Stage BRAM_LATENCY-1 lines up with bram_dout for the read enabled BRAM_LATENCY cycles earlier.
      sr_vld[0]  <= bram_en;
      sr_last[0] <= bram_en && en_last;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
    end
  end

  bram_rd_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (sr_vld[BRAM_LATENCY-1]),
    .wdata({sr_last[BRAM_LATENCY-1], bram_dout}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_rdata[DATA_WIDTH];

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && sr_vld[BRAM_LATENCY-1] && !pop));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a latency-2, 16-word BRAM model.
module tb_bram_stream_reader;

  localparam int DW  = 64;
  localparam int DD  = 16;
  localparam int LAT = 2;
  localparam int AW  = 4;
  localparam int LW  = 5;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  logic [DW-1:0] mem  [DD];
  logic [DW-1:0] pipe [LAT];

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            checks = 0;
  int            errors = 0;
  int            issued = 0;
  int            popped = 0;
  int            stall_checks = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DD), .BRAM_LATENCY(LAT), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always @(posedge clk) begin
    pipe[0] <= mem[bram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_dout = pipe[LAT-1];

  // Port monitor: read addresses, outstanding reads, beats and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (bram_en) begin
        issued++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_unexpected: bram_addr=%0d, no read expected", bram_addr);
        end else begin
          logic [AW-1:0] a;
          a = addr_q.pop_front();
          if (bram_addr !== a) begin
            errors++;
            $display("FAIL addr_seq: got %0d want %0d", bram_addr, a);
          end
        end
        checks++;
        if (issued - popped > 4) begin
          errors++;
          $display("FAIL outstanding: got %0d want <= 4", issued - popped);
        end
      end
      if (stall_prev) begin
        stall_checks++;
        checks++;
        if (m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
          errors++;
          $display("FAIL stall_stable: got %0d/%0b want %0d/%0b", m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: tdata=%0d", m_axis_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.dat || m_axis_tlast !== e.last) begin
            errors++;
            $display("FAIL beat: got %0d last=%0b want %0d last=%0b", m_axis_tdata, m_axis_tlast, e.dat, e.last);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  // Pulse start; optionally queue the addresses and beats the command must produce.
  task automatic issue_cmd(input int b, input int l, input bit expect_it);
    if (expect_it) begin
      for (int i = 0; i < l; i++) begin
        int a;
        a = (b + i) % DD;
        addr_q.push_back(AW'(a));
        exp_q.push_back('{dat: DW'(a + 100), last: (i == l - 1)});
      end
    end
    @(posedge clk); #1;
    base_addr = AW'(b);
    length    = LW'(l);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, bram_en, bram_addr, m_axis_tvalid, m_axis_tlast} !== '0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b en=%0b addr=%0d tvalid=%0b tdata=%0d tlast=%0b want all 0",
               busy, done, bram_en, bram_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    int first_en, first_vld, done_cyc, done_cnt;
    logic busy0, busy_at_done;
    first_en = -1; first_vld = -1; done_cyc = -1; done_cnt = 0;
    busy0 = 1'b0; busy_at_done = 1'b1;
    m_axis_tready = 1'b1;
    issue_cmd(3, 4, 1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (bram_en && first_en < 0) first_en = k;
      if (m_axis_tvalid && first_vld < 0) first_vld = k;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          busy_at_done = busy;
        end
      end
    end
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", busy0); end
    checks++;
    if (first_en != 1) begin errors++; $display("FAIL basic_first_en: got cycle %0d want 1", first_en); end
    checks++;
    if (first_vld != 4) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want 4", first_vld); end
    checks++;
    if (done_cyc != 8 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: got cycle %0d count %0d want cycle 8 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b want 0", busy_at_done); end
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d beats %0d reads left want 0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_wrap;
    int cyc;
    issue_cmd(14, 4, 1);
    wait_done(40, cyc);
    checks++;
    if (cyc < 0 || exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: done cycle %0d, %0d beats %0d reads left, want done and 0 left", cyc, exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_backpressure;
    int cyc, p0, s0;
    p0 = popped;
    s0 = stall_checks;
    issue_cmd(9, 8, 1);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (popped - p0 >= 2) break;
    end
    m_axis_tready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_done(60, cyc);
    checks++;
    if (cyc < 0 || exp_q.size() != 0 || popped - p0 != 8) begin
      errors++;
      $display("FAIL backpressure: done cycle %0d, beats %0d, %0d left, want 8 beats and 0 left", cyc, popped - p0, exp_q.size());
    end
    checks++;
    if (stall_checks - s0 < 9) begin
      errors++;
      $display("FAIL backpressure_stall: got %0d stalled cycles want >= 9", stall_checks - s0);
    end
  endtask

  task automatic test_zero;
    int en_cnt, vld_cnt;
    logic d0, b0, d1;
    en_cnt = 0; vld_cnt = 0;
    issue_cmd(7, 0, 1);
    @(negedge clk);
    d0 = done; b0 = busy;
    if (bram_en) en_cnt++;
    if (m_axis_tvalid) vld_cnt++;
    @(negedge clk);
    d1 = done;
    for (int k = 0; k < 6; k++) begin
      if (bram_en) en_cnt++;
      if (m_axis_tvalid) vld_cnt++;
      @(negedge clk);
    end
    checks++;
    if (d0 !== 1'b1 || b0 !== 1'b0 || d1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%0b busy=%0b then done=%0b want 1,0 then 0", d0, b0, d1);
    end
    checks++;
    if (en_cnt != 0 || vld_cnt != 0) begin
      errors++;
      $display("FAIL zero_activity: got %0d reads %0d valid cycles want 0", en_cnt, vld_cnt);
    end
  endtask

  task automatic test_start_busy;
    int cyc, p0;
    p0 = popped;
    issue_cmd(3, 6, 1);
    @(posedge clk); #1;
    base_addr = '0;
    length    = LW'(2);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, cyc);
    repeat (8) @(negedge clk);
    checks++;
    if (cyc < 0 || popped - p0 != 6 || exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL start_busy: done cycle %0d, got %0d beats want 6, %0d left", cyc, popped - p0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc, p0;
    issue_cmd(8, 6, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bram_en, bram_addr, m_axis_tvalid, m_axis_tlast} !== '0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%0b en=%0b addr=%0d tvalid=%0b tdata=%0d want all 0",
               busy, bram_en, bram_addr, m_axis_tvalid, m_axis_tdata);
    end
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    popped = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = popped;
    issue_cmd(5, 2, 1);
    wait_done(30, cyc);
    repeat (8) @(negedge clk);
    checks++;
    if (cyc < 0 || popped - p0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_restart: done cycle %0d, got %0d beats want 2, %0d left", cyc, popped - p0, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DD; i++) mem[i] = DW'(i + 100);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
